// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: each BLOCK_WIDTH slice is resolved by a flat
// lookahead block in its own stage, with a registered carry and valid/ready bubble collapsing.
module pipelined_cla_adder #(
  parameter int ADDER_WIDTH = 32,
  parameter int BLOCK_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDER_WIDTH-1:0] a,
  input  logic [ADDER_WIDTH-1:0] b,
  input  logic                   cin,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDER_WIDTH-1:0] sum,
  output logic                   carry_out,
  output logic                   overflow
);

  localparam int NUM_BLOCKS = ADDER_WIDTH / BLOCK_WIDTH;
  localparam int W  = ADDER_WIDTH;
  localparam int BW = BLOCK_WIDTH;
  localparam int NB = NUM_BLOCKS;

  generate
    if (BLOCK_WIDTH < 1 || BLOCK_WIDTH > ADDER_WIDTH || (ADDER_WIDTH % BLOCK_WIDTH) != 0) begin : g_bad_cfg
      $error("pipelined_cla_adder: ADDER_WIDTH must be a multiple of BLOCK_WIDTH (1..ADDER_WIDTH)");
    end
  endgenerate

  // Every carry is a flat sum-of-products of the block's g/p terms and its carry-in.
  function automatic logic [BW:0] cla_carries(input logic [BW-1:0] p,
                                              input logic [BW-1:0] g,
                                              input logic          ci);
    logic [BW:0] c;
    logic        term;
    c    = '0;
    c[0] = ci;
    for (int i = 1; i <= BW; i++) begin
      term = ci;
      for (int j = 0; j < i; j++) term = term & p[j];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        c[i] = c[i] | term;
      end
    end
    return c;
  endfunction

  logic [NB:0]   rdy;
  logic [NB-1:0] v_q, v_d;
  logic [NB-1:0] c_q, c_d;
  logic [W-1:0]  a_q [NB];
  logic [W-1:0]  a_d [NB];
  logic [W-1:0]  b_q [NB];
  logic [W-1:0]  b_d [NB];
  logic [W-1:0]  s_q [NB];
  logic [W-1:0]  s_d [NB];
  logic          ovf_q, ovf_d;

  logic [NB-1:0] up_v;
  logic [NB-1:0] up_c;
  logic [W-1:0]  up_a [NB];
  logic [W-1:0]  up_b [NB];
  logic [W-1:0]  up_s [NB];

  // Stage 0 sees the pre-processed operands; later stages see the previous stage's payload.
  assign up_v[0] = in_valid;
  assign up_a[0] = a;
  assign up_b[0] = sub ? ~b : b;
  assign up_s[0] = '0;
  assign up_c[0] = sub ? 1'b1 : cin;

  generate
    for (genvar k = 1; k < NB; k++) begin : g_link
      assign up_v[k] = v_q[k-1];
      assign up_a[k] = a_q[k-1];
      assign up_b[k] = b_q[k-1];
      assign up_s[k] = s_q[k-1];
      assign up_c[k] = c_q[k-1];
    end
  endgenerate

  // NOTE: every variable written here gets a value on every path first, so no latch is inferred.
  always_comb begin
    logic [BW-1:0] blk_p;
    logic [BW-1:0] blk_g;
    logic [BW:0]   blk_c;
    rdy[NB] = out_ready;
    for (int k = NB - 1; k >= 0; k--) rdy[k] = !v_q[k] || rdy[k+1];
    ovf_d = ovf_q;
    for (int k = 0; k < NB; k++) begin
      blk_p  = up_a[k][k*BW +: BW] ^ up_b[k][k*BW +: BW];
      blk_g  = up_a[k][k*BW +: BW] & up_b[k][k*BW +: BW];
      blk_c  = cla_carries(blk_p, blk_g, up_c[k]);
      v_d[k] = rdy[k] ? up_v[k] : v_q[k];
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
      c_d[k] = c_q[k];
      if (rdy[k] && up_v[k]) begin
        a_d[k]               = up_a[k];
        b_d[k]               = up_b[k];
        s_d[k]               = up_s[k];
        s_d[k][k*BW +: BW]   = blk_p ^ blk_c[BW-1:0];
        c_d[k]               = blk_c[BW];
        if (k == NB - 1) ovf_d = blk_c[BW] ^ blk_c[BW-1];
      end
    end
  end

  // NOTE: state updates use non-blocking assignments; the datapath is reset too so outputs read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < NB; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < NB; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[NB-1];
  assign sum       = s_q[NB-1];
  assign carry_out = c_q[NB-1];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: stimulus pushes expected results, a monitor pops
// and compares them whenever the adder presents a result.
module tb_pipelined_cla_adder;

  localparam int W = 32;
  parameter int BW = 8;
  localparam int N = W / BW;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           cyc;
    bit           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  logic out_ready_dir = 1'b1;
  logic rnd_rdy = 1'b1;
  bit   rand_en = 1'b0;
  bit   lat_chk = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  assign out_ready = rand_en ? rnd_rdy : out_ready_dir;

  pipelined_cla_adder #(.ADDER_WIDTH(W), .BLOCK_WIDTH(BW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry_out(carry_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    rnd_rdy = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] xb,
                                 input logic tc, input logic ts);
    logic [W:0]   r;
    logic [W-1:0] be;
    exp_t         e;
    be     = ts ? ~xb : xb;
    r      = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, (ts ? 1'b1 : tc)};
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.ovf  = (ta[W-1] == be[W-1]) && (r[W-1] != ta[W-1]);
    e.cyc  = 0;
    e.lat  = 1'b0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick();
    in_valid = 1'b0;
  endtask

  // Presents one operation and records its expected result on the transfer cycle.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] xb,
                      input logic tc, input logic ts, input exp_t e);
    int   waited;
    exp_t en;
    tick();
    in_valid = 1'b1;
    a = ta;
    b = xb;
    cin = tc;
    sub = ts;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 1000) begin
        check("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        return;
      end
    end
    en = e;
    en.cyc = cyc;
    en.lat = lat_chk;
    sb.push_back(en);
  endtask

  task automatic send_d(input logic [W-1:0] ta, input logic [W-1:0] xb, input logic tc,
                        input logic ts, input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    e.sum = es;
    e.cout = ec;
    e.ovf = eo;
    e.cyc = 0;
    e.lat = 1'b0;
    send(ta, xb, tc, ts, e);
  endtask

  task automatic send_m(input logic [W-1:0] ta, input logic [W-1:0] xb,
                        input logic tc, input logic ts);
    send(ta, xb, tc, ts, model(ta, xb, tc, ts));
  endtask

  // Monitor: compares the head of the scoreboard every cycle a result is presented.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (!in_ready) check("in_ready_low_without_stall", 64'(out_ready), 64'd0);
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          check("sum", 64'(sum), 64'(sb[0].sum));
          check("carry_out", 64'(carry_out), 64'(sb[0].cout));
          check("overflow", 64'(overflow), 64'(sb[0].ovf));
          if (sb[0].lat) check("latency", 64'(cyc - sb[0].cyc), 64'(N));
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    int nres;
    repeat (2) @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_sum", 64'(sum), 64'd0);
    check("reset_carry_out", 64'(carry_out), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Directed vectors, no backpressure, latency checked on each.
    lat_chk = 1'b1;
    send_d(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    send_d(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    send_d(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    send_d(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    send_d(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    send_d(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    send_d(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    send_d(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    send_d(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0);
    send_d(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    send_d(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    idle();
    repeat (N + 3) tick();

    // Bubble collapse: a lone stalled op must not block the input until the pipe is full.
    lat_chk = 1'b0;
    out_ready_dir = 1'b0;
    send_m(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0);
    idle();
    repeat (N + 2) tick();
    @(negedge clk);
    check("in_ready_one_op_held", 64'(in_ready), (N > 1) ? 64'd1 : 64'd0);
    for (int i = 1; i < N; i++) send_m(32'h1000_0000 * i, 32'h0000_1111 * i, 1'b0, 1'(i % 2));
    idle();
    @(negedge clk);
    check("in_ready_pipe_full", 64'(in_ready), 64'd0);
    tick();
    out_ready_dir = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check("drain_one_per_cycle", 64'(out_valid), 64'd1);
    end
    repeat (3) tick();

    // Reset while results are held in the pipe.
    out_ready_dir = 1'b0;
    nres = (N < 3) ? N : 3;
    for (int i = 0; i < nres; i++) send_m(32'hCAFE_0000 + i, 32'h0000_F00D, 1'b0, 1'b0);
    idle();
    repeat (N) tick();
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_sum", 64'(sum), 64'd0);
    check("midreset_carry_out", 64'(carry_out), 64'd0);
    check("midreset_overflow", 64'(overflow), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    out_ready_dir = 1'b1;
    lat_chk = 1'b1;
    send_d(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_0031, 1'b0, 1'b0);
    idle();
    repeat (N + 3) tick();

    // Streaming with pseudo-random backpressure.
    lat_chk = 1'b0;
    rand_en = 1'b1;
    for (int i = 0; i < 20; i++)
      send_m($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle();
    rand_en = 1'b0;
    out_ready_dir = 1'b1;
    for (int i = 0; i < 500 && (sb.size() != 0 || out_valid); i++) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It is the successor to the team's single-cycle combinational CLA. The operand is split into blocks of BLOCK_WIDTH bits. Each block uses full lookahead internally (group P/G, no ripple) and forms one pipeline stage, with a registered carry between stages. It adds add/sub mode, signed overflow and a valid/ready handshake with per-stage bubble collapsing, and sits in the datapath wherever wide adds must meet timing at high clock rates.

Parameters:
ADDER_WIDTH, 32, operand/sum width in bits; must be a multiple of BLOCK_WIDTH (elaboration error otherwise).
BLOCK_WIDTH, 8, bits resolved per pipeline stage by a full lookahead block; 1..ADDER_WIDTH.
NUM_BLOCKS, ADDER_WIDTH/BLOCK_WIDTH, derived (localparam); equals pipeline depth and latency.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and mode valid this cycle
in_ready  output  1  stage 0 can accept; transfer when in_valid & in_ready
a  input  ADDER_WIDTH  operand A
b  input  ADDER_WIDTH  operand B
cin  input  1  carry-in (add mode only)
sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1, cin ignored)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts; transfer when out_valid & out_ready
sum  output  ADDER_WIDTH  result (mod 2^ADDER_WIDTH)
carry_out  output  1  carry out of MSB; in sub mode 1 = no borrow (a >= b unsigned)
overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (asynchronous assert on rst_n low; synchronous-safe deassert on clk):
  - all stage valid bits 0 and all data registers 0
  - out_valid=0, sum=0, carry_out=0, overflow=0
  - in_ready=1 one combinational step after reset releases
- Operand pre-processing at input:
  - b_eff = sub ? ~b : b
  - c0 = sub ? 1 : cin
- Stage k (k=0..NUM_BLOCKS-1):
  - register v[k] plus a payload: skewed remaining operand bits, completed low sum bits, block carry.
  - stage k computes sum bits [k*BW +: BW] from its operand slice and the incoming carry (c0 for k=0, registered carry from stage k-1 otherwise).
  - p_i = a_i ^ b_i, g_i = a_i & b_i; every carry inside the block is computed as a lookahead sum-of-products from the block's carry-in; no ripple chain inside a block.
  - the last stage also records the carry into the MSB for overflow.
- Latency: exactly NUM_BLOCKS cycles from input transfer to out_valid with no backpressure (default 4). Throughput is 1 op/cycle.
- Handshake / flow control:
  - rdy[NUM_BLOCKS] = out_ready; rdy[k] = !v[k] | rdy[k+1]; in_ready = rdy[0].
  - stage k loads when rdy[k] is high: v[k] <= upstream valid (in_valid for k=0); payload loads only when upstream valid is 1.
  - a stage with rdy[k]=0 holds payload and valid unchanged.
  - bubbles collapse: an empty stage accepts even while downstream stalls.
  - out_valid = v[NUM_BLOCKS-1]; sum/carry_out/overflow stay stable while out_valid & !out_ready.
  - in_valid is not required to stay asserted without in_ready (source-side rule); the block samples only on a transfer.
- Simultaneous events: a full pipe with out_ready=1 accepts a new input in the same cycle the oldest result leaves (in_ready=1).
- Reset mid-operation: all in-flight results are discarded with no partial output; the first post-reset result has full latency.
- Degenerate configs:
  - BLOCK_WIDTH=ADDER_WIDTH gives a single-stage registered CLA with latency 1.
  - BLOCK_WIDTH=1 gives a bit-serial-skew pipeline with latency ADDER_WIDTH.
- Ordering: results leave strictly in acceptance order; no reordering or drop.

Test Plan:
- Reset then add, 32/8: a=0x0000_00FF, b=0x0000_0001, cin=0, out_ready=1 -> after 4 cycles sum=0x0000_0100, carry_out=0, overflow=0; out_valid high exactly 1 cycle.
- Full carry propagate: a=0xFFFF_FFFF, b=0, cin=1 -> sum=0, carry_out=1, overflow=0. Also a=0x7FFF_FFFF, b=1 -> sum=0x8000_0000, overflow=1.
- Subtract: sub=1, a=5, b=7 -> sum=0xFFFF_FFFE, carry_out=0. Then a=7, b=5 -> sum=2, carry_out=1. Then a=0x8000_0000, b=1 -> overflow=1. cin toggled has no effect.
- Streaming/backpressure: 20 back-to-back random ops with out_ready toggling pseudo-randomly -> all results match the golden model, in order, none lost or duplicated; outputs stable while stalled; in_ready=0 only when all 4 stages are full and out_ready=0.
- Bubble collapse: send 1 op, hold out_ready=0 -> in_ready stays 1 until 4 ops are held; then in_ready=0; release out_ready -> results drain 1/cycle.
- Reset mid-flight: 3 ops in pipe, pulse rst_n low asynchronously between edges -> out_valid=0 and sum=0 immediately; no stale result appears afterwards. Repeat the sweep with BLOCK_WIDTH=32 (latency 1) and BLOCK_WIDTH=4 (latency 8).
